receptor_comandos_serial: RTL and testbench

- Consumes the RX line that feeds the tank-control top level.
- Deserialises UART 8N1 frames and decodes single-ASCII-byte remote commands into level/pulse controls: manual valve override, remote measurement start, return to automatic mode.
- Sits between the RX pin and the UC/valve logic.
- Also reports framing and unknown-command errors.

---
 rtl/receptor_comandos_serial_pkg.sv | 45 ++++
 rtl/receptor_comandos_serial_rx.sv | 92 +++++++++
 rtl/receptor_comandos_serial.sv | 84 ++++++++
 tb/tb_receptor_comandos_serial.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/receptor_comandos_serial_pkg.sv
// Shared definitions for the serial command receiver: RX FSM state codes,
// accepted command bytes and the byte-to-command decoder.
package receptor_comandos_serial_pkg;

  localparam int CLKS_PER_BIT_PADRAO = 434;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    INICIO      = 4'd1,
    DADOS       = 4'd2,
    PARADA      = 4'd3,
    DECODIFICA  = 4'd4,
    ESPERA_ALTO = 4'd5
  } estado_rx_t;

  localparam logic [7:0] CMD_ABRE      = 8'h41;
  localparam logic [7:0] CMD_ABRE_MIN  = 8'h61;
  localparam logic [7:0] CMD_FECHA     = 8'h46;
  localparam logic [7:0] CMD_FECHA_MIN = 8'h66;
  localparam logic [7:0] CMD_MEDE      = 8'h4D;
  localparam logic [7:0] CMD_MEDE_MIN  = 8'h6D;
  localparam logic [7:0] CMD_AUTO      = 8'h52;
  localparam logic [7:0] CMD_AUTO_MIN  = 8'h72;

  typedef enum logic [2:0] {
    C_INVALIDO = 3'd0,
    C_ABRE     = 3'd1,
    C_FECHA    = 3'd2,
    C_MEDE     = 3'd3,
    C_AUTO     = 3'd4
  } comando_t;

  function automatic comando_t decodifica_cmd(input logic [7:0] b);
    comando_t c;
    case (b)
      CMD_ABRE,  CMD_ABRE_MIN:  c = C_ABRE;
      CMD_FECHA, CMD_FECHA_MIN: c = C_FECHA;
      CMD_MEDE,  CMD_MEDE_MIN:  c = C_MEDE;
      CMD_AUTO,  CMD_AUTO_MIN:  c = C_AUTO;
      default:                  c = C_INVALIDO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/receptor_comandos_serial_rx.sv
// UART 8N1 deserialiser: input synchroniser, start validation at half bit,
// centre sampling of data/stop, break handling; strobes a good or bad frame.
module rx_serial_8n1
  import receptor_comandos_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] dado,
  output logic       byte_valido,
  output logic       erro_quadro,
  output logic [3:0] estado_atual
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_FIM  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] MEIO_FIM = TW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sinc;
  logic                   rx_s;
  estado_rx_t             estado;
  logic [TW-1:0]          timer;
  logic [2:0]             indice;
  logic                   amostra_bit;

  // Preset to idle level so reset release never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinc <= '1;
    else        sinc <= {sinc[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sinc[SYNC_STAGES-1];

  assign amostra_bit = (estado == DADOS) && (timer == BIT_FIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      timer  <= '0;
      indice <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          timer  <= '0;
          indice <= '0;
          if (!rx_s) estado <= INICIO;
        end
        INICIO: begin
          if (timer == MEIO_FIM) begin
            timer  <= '0;
            estado <= rx_s ? OCIOSO : DADOS;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DADOS: begin
          if (timer == BIT_FIM) begin
            timer  <= '0;
            indice <= indice + 3'd1;
            if (indice == 3'd7) estado <= PARADA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PARADA: begin
          if (timer == BIT_FIM) begin
            timer  <= '0;
            estado <= rx_s ? DECODIFICA : ESPERA_ALTO;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DECODIFICA:  estado <= OCIOSO;
        ESPERA_ALTO: if (rx_s) estado <= OCIOSO;
        default:     estado <= OCIOSO;
      endcase
    end
  end

  // Data shift register, LSB arrives first; never observed before a full frame
  always_ff @(posedge clock) begin
    if (amostra_bit) dado <= {rx_s, dado[7:1]};
  end

  assign byte_valido  = (estado == PARADA) && (timer == BIT_FIM) &&  rx_s;
  assign erro_quadro  = (estado == PARADA) && (timer == BIT_FIM) && !rx_s;
  assign estado_atual = estado;

endmodule

// File: rtl/receptor_comandos_serial.sv
// Remote command receiver: decodes single-byte UART commands into valve
// override pulses/levels, remote measurement start and error pulses.
module receptor_comandos_serial
  import receptor_comandos_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic       abre_manual,
  output logic       fecha_manual,
  output logic       iniciar_remoto,
  output logic       modo_manual,
  output logic       valvula_manual,
  output logic [7:0] dado_recebido,
  output logic       erro_quadro,
  output logic       cmd_invalido,
  output logic [3:0] db_estado
);

  logic [7:0] dado_rx;
  logic       quadro_ok;
  logic       quadro_erro;
  comando_t   cmd;

  rx_serial_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (RX),
    .dado        (dado_rx),
    .byte_valido (quadro_ok),
    .erro_quadro (quadro_erro),
    .estado_atual(db_estado)
  );

  assign cmd = decodifica_cmd(dado_rx);

  // Registered on the stop-bit sample edge, so every effect shows during DECODIFICA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      abre_manual    <= 1'b0;
      fecha_manual   <= 1'b0;
      iniciar_remoto <= 1'b0;
      cmd_invalido   <= 1'b0;
      erro_quadro    <= 1'b0;
      modo_manual    <= 1'b0;
      valvula_manual <= 1'b0;
      dado_recebido  <= 8'h00;
    end else begin
      abre_manual    <= 1'b0;
      fecha_manual   <= 1'b0;
      iniciar_remoto <= 1'b0;
      cmd_invalido   <= 1'b0;
      erro_quadro    <= quadro_erro;
      if (quadro_ok) begin
        dado_recebido <= dado_rx;
        case (cmd)
          C_ABRE: begin
            abre_manual    <= 1'b1;
            modo_manual    <= 1'b1;
            valvula_manual <= 1'b1;
          end
          C_FECHA: begin
            fecha_manual   <= 1'b1;
            modo_manual    <= 1'b1;
            valvula_manual <= 1'b0;
          end
          C_MEDE: iniciar_remoto <= 1'b1;
          C_AUTO: begin
            modo_manual    <= 1'b0;
            valvula_manual <= 1'b0;
          end
          default: cmd_invalido <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receptor_comandos_serial.sv
// Directed bench for receptor_comandos_serial at 434 clocks per bit.
module tb_receptor_comandos_serial;

  localparam int C = 434;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RX    = 1'b1;
  logic       abre_manual, fecha_manual, iniciar_remoto, modo_manual;
  logic       valvula_manual, erro_quadro, cmd_invalido;
  logic [7:0] dado_recebido;
  logic [3:0] db_estado;

  int checks = 0;
  int failures = 0;

  int ciclo = 0;
  int cnt_abre, cnt_fecha, cnt_mede, cnt_erro, cnt_inv, multi;
  int t_queda, t_abre;
  logic v_fecha, m_fecha, viu_espera, rx_ant = 1'b1;

  receptor_comandos_serial #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .RX            (RX),
    .abre_manual   (abre_manual),
    .fecha_manual  (fecha_manual),
    .iniciar_remoto(iniciar_remoto),
    .modo_manual   (modo_manual),
    .valvula_manual(valvula_manual),
    .dado_recebido (dado_recebido),
    .erro_quadro   (erro_quadro),
    .cmd_invalido  (cmd_invalido),
    .db_estado     (db_estado)
  );

  always #10 clock = ~clock;

  // Observe outputs 1 time unit after each rising edge
  always @(posedge clock) begin
    #1;
    ciclo++;
    if (RX === 1'b0 && rx_ant === 1'b1 && t_queda < 0) t_queda = ciclo;
    rx_ant = RX;
    if (abre_manual === 1'b1) begin
      cnt_abre++;
      if (t_abre < 0) t_abre = ciclo;
    end
    if (fecha_manual === 1'b1) begin
      cnt_fecha++;
      v_fecha = valvula_manual;
      m_fecha = modo_manual;
    end
    if (iniciar_remoto === 1'b1) cnt_mede++;
    if (erro_quadro === 1'b1) cnt_erro++;
    if (cmd_invalido === 1'b1) cnt_inv++;
    if (db_estado === 4'd5) viu_espera = 1'b1;
    if (int'(abre_manual) + int'(fecha_manual) + int'(iniciar_remoto) +
        int'(erro_quadro) + int'(cmd_invalido) > 1) multi++;
  end

  task automatic zera();
    cnt_abre = 0; cnt_fecha = 0; cnt_mede = 0; cnt_erro = 0; cnt_inv = 0;
    t_queda = -1; t_abre = -1; v_fecha = 1'bx; m_fecha = 1'bx;
    viu_espera = 1'b0;
  endtask

  task automatic envia_bit(input logic b, input int n);
    RX = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic envia_quadro(input logic [7:0] b, input logic stop);
    logic [7:0] v;
    v = b;
    envia_bit(1'b0, C);
    for (int i = 0; i < 8; i++) envia_bit(v[i], C);
    envia_bit(stop, C);
  endtask

  task automatic test_reset();
    RX = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (abre_manual !== 1'b0 || fecha_manual !== 1'b0 || iniciar_remoto !== 1'b0) begin failures++; $display("FAIL reset_pulsos got=%b%b%b exp=000", abre_manual, fecha_manual, iniciar_remoto); end
    checks++; if (erro_quadro !== 1'b0 || cmd_invalido !== 1'b0) begin failures++; $display("FAIL reset_erros got=%b%b exp=00", erro_quadro, cmd_invalido); end
    checks++; if (modo_manual !== 1'b0 || valvula_manual !== 1'b0) begin failures++; $display("FAIL reset_modo got=%b%b exp=00", modo_manual, valvula_manual); end
    checks++; if (dado_recebido !== 8'h00) begin failures++; $display("FAIL reset_dado got=%h exp=00", dado_recebido); end
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL pos_reset_estado got=%0d exp=0", db_estado); end
  endtask

  task automatic test_abre();
    zera();
    envia_quadro(8'h41, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_abre !== 1) begin failures++; $display("FAIL abre_pulsos got=%0d exp=1", cnt_abre); end
    checks++; if (t_abre - t_queda !== 4125) begin failures++; $display("FAIL abre_latencia got=%0d exp=4125", t_abre - t_queda); end
    checks++; if (modo_manual !== 1'b1 || valvula_manual !== 1'b1) begin failures++; $display("FAIL abre_modo got=%b%b exp=11", modo_manual, valvula_manual); end
    checks++; if (dado_recebido !== 8'h41) begin failures++; $display("FAIL abre_dado got=%h exp=41", dado_recebido); end
    checks++; if (cnt_fecha + cnt_mede + cnt_erro + cnt_inv !== 0) begin failures++; $display("FAIL abre_outros got=%0d exp=0", cnt_fecha + cnt_mede + cnt_erro + cnt_inv); end
  endtask

  task automatic test_back_to_back();
    zera();
    envia_quadro(8'h66, 1'b1);
    envia_quadro(8'h52, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_fecha !== 1) begin failures++; $display("FAIL b2b_fecha got=%0d exp=1", cnt_fecha); end
    checks++; if (v_fecha !== 1'b0 || m_fecha !== 1'b1) begin failures++; $display("FAIL b2b_fecha_nivel got=v%b m%b exp=v0 m1", v_fecha, m_fecha); end
    checks++; if (modo_manual !== 1'b0 || valvula_manual !== 1'b0) begin failures++; $display("FAIL b2b_auto got=%b%b exp=00", modo_manual, valvula_manual); end
    checks++; if (dado_recebido !== 8'h52) begin failures++; $display("FAIL b2b_dado got=%h exp=52", dado_recebido); end
    checks++; if (cnt_erro + cnt_inv + cnt_abre + cnt_mede !== 0) begin failures++; $display("FAIL b2b_outros got=%0d exp=0", cnt_erro + cnt_inv + cnt_abre + cnt_mede); end
  endtask

  task automatic test_glitch();
    zera();
    envia_bit(1'b0, 50);
    checks++; if (db_estado !== 4'd1) begin failures++; $display("FAIL glitch_inicio got=%0d exp=1", db_estado); end
    envia_bit(1'b0, 50);
    envia_bit(1'b1, 400);
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL glitch_estado got=%0d exp=0", db_estado); end
    checks++; if (cnt_abre + cnt_fecha + cnt_mede + cnt_erro + cnt_inv !== 0) begin failures++; $display("FAIL glitch_pulsos got=%0d exp=0", cnt_abre + cnt_fecha + cnt_mede + cnt_erro + cnt_inv); end
    checks++; if (dado_recebido !== 8'h52) begin failures++; $display("FAIL glitch_dado got=%h exp=52", dado_recebido); end
  endtask

  task automatic test_erro_quadro();
    zera();
    envia_quadro(8'h4D, 1'b0);
    envia_bit(1'b0, 5 * C);
    envia_bit(1'b1, C);
    checks++; if (cnt_erro !== 1) begin failures++; $display("FAIL erro_pulsos got=%0d exp=1", cnt_erro); end
    checks++; if (cnt_mede !== 0) begin failures++; $display("FAIL erro_mede got=%0d exp=0", cnt_mede); end
    checks++; if (viu_espera !== 1'b1) begin failures++; $display("FAIL erro_espera_alto got=%b exp=1", viu_espera); end
    checks++; if (dado_recebido !== 8'h52) begin failures++; $display("FAIL erro_dado got=%h exp=52", dado_recebido); end
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL erro_estado got=%0d exp=0", db_estado); end
    zera();
    envia_quadro(8'h6D, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_mede !== 1) begin failures++; $display("FAIL mede_pulsos got=%0d exp=1", cnt_mede); end
    checks++; if (dado_recebido !== 8'h6D || modo_manual !== 1'b0) begin failures++; $display("FAIL mede_dado got=%h m%b exp=6d m0", dado_recebido, modo_manual); end
  endtask

  task automatic test_invalido();
    zera();
    envia_quadro(8'h61, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_abre !== 1 || modo_manual !== 1'b1 || valvula_manual !== 1'b1) begin failures++; $display("FAIL abre_min got=%0d m%b v%b exp=1 m1 v1", cnt_abre, modo_manual, valvula_manual); end
    zera();
    envia_quadro(8'h78, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_inv !== 1) begin failures++; $display("FAIL inv_pulsos got=%0d exp=1", cnt_inv); end
    checks++; if (modo_manual !== 1'b1 || valvula_manual !== 1'b1) begin failures++; $display("FAIL inv_modo got=%b%b exp=11", modo_manual, valvula_manual); end
    checks++; if (dado_recebido !== 8'h78) begin failures++; $display("FAIL inv_dado got=%h exp=78", dado_recebido); end
    checks++; if (cnt_abre + cnt_fecha + cnt_mede + cnt_erro !== 0) begin failures++; $display("FAIL inv_outros got=%0d exp=0", cnt_abre + cnt_fecha + cnt_mede + cnt_erro); end
  endtask

  task automatic test_reset_meio_quadro();
    logic [7:0] v;
    v = 8'h41;
    zera();
    envia_bit(1'b0, C);
    for (int i = 0; i < 4; i++) envia_bit(v[i], C);
    envia_bit(v[4], C / 2);
    reset = 1'b0;
    #1;
    checks++; if (modo_manual !== 1'b0 || valvula_manual !== 1'b0) begin failures++; $display("FAIL rst_meio_modo got=%b%b exp=00", modo_manual, valvula_manual); end
    checks++; if (dado_recebido !== 8'h00 || db_estado !== 4'd0) begin failures++; $display("FAIL rst_meio_dado got=%h e%0d exp=00 e0", dado_recebido, db_estado); end
    RX = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    envia_bit(1'b1, C);
    checks++; if (cnt_abre + cnt_fecha + cnt_mede + cnt_erro + cnt_inv !== 0 || db_estado !== 4'd0) begin failures++; $display("FAIL rst_meio_silencio got=%0d e%0d exp=0 e0", cnt_abre + cnt_fecha + cnt_mede + cnt_erro + cnt_inv, db_estado); end
    zera();
    envia_quadro(8'h41, 1'b1);
    envia_bit(1'b1, 20);
    checks++; if (cnt_abre !== 1 || t_abre - t_queda !== 4125) begin failures++; $display("FAIL rst_meio_abre got=%0d lat=%0d exp=1 lat=4125", cnt_abre, t_abre - t_queda); end
    checks++; if (dado_recebido !== 8'h41 || modo_manual !== 1'b1 || valvula_manual !== 1'b1) begin failures++; $display("FAIL rst_meio_estado got=%h m%b v%b exp=41 m1 v1", dado_recebido, modo_manual, valvula_manual); end
  endtask

  initial begin
    multi = 0;
    zera();
    test_reset();
    test_abre();
    test_back_to_back();
    test_glitch();
    test_erro_quadro();
    test_invalido();
    test_reset_meio_quadro();
    checks++; if (multi !== 0) begin failures++; $display("FAIL pulso_unico got=%0d exp=0", multi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
